mux_scan_seq: RTL and testbench

Sequencer stage that drives a 4:1 muxer. On a start request it latches a parallel word and presents it on the muxer data inputs. It then steps the muxer select through every input, one per clock, and samples the muxer output each cycle. The sampled bits come out as a serial stream and as a reassembled parallel word, so the block is both the muxer's upstream driver and its downstream consumer.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/mux_scan_seq.sv | 103 ++++++++++
 tb/tb_mux_scan_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

  // Default number of muxer inputs / scanned word width.
  localparam int MUX_SCAN_WIDTH = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } scan_state_t;

endpackage

// File: rtl/mux_scan_seq.sv
// Sequencer that drives an external WIDTH:1 muxer and consumes its output.
// A start request latches a word onto the muxer inputs. The block then walks
// the select through every input, one per clock, and registers each muxer
// output bit. The bits come out serially and as a reassembled parallel word.
//
// Optional build macro: SCAN_CHECK_EN adds the err port and the compare of
// the reassembled word against the latched word.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; mux_sel held at 0
// SCAN  | select = cnt, one muxer input sampled per clock
// DONE  | one-cycle completion pulse, rx_word complete
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH = MUX_SCAN_WIDTH,
  localparam int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [WIDTH-1:0] rx_word,
  output logic             busy,
  output logic             done
`ifdef SCAN_CHECK_EN
  ,output logic            err
`endif
);

  scan_state_t      state;
  logic [SEL_W-1:0] cnt;
  logic             last_sel;
  logic             accept;

  assign last_sel = (cnt == SEL_W'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;

  // State register: IDLE -> SCAN on start, SCAN -> DONE after the last select,
  // DONE always falls back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= SCAN;
        SCAN:    if (last_sel) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Word latch, select counter and capture path. mux_q is only ever
  // registered, so a glitching muxer cannot reach ser_out between edges.
  // cnt wraps to 0 after the last select; by then the state has left SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_in    <= '0;
      cnt       <= '0;
      rx_word   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      if (accept) begin
        mux_in  <= data_in;
        cnt     <= '0;
        rx_word <= '0;
      end else if (state == SCAN) begin
        ser_out      <= mux_q;
        ser_valid    <= 1'b1;
        rx_word[cnt] <= mux_q;
        cnt          <= cnt + SEL_W'(1);
      end
    end
  end

`ifdef SCAN_CHECK_EN
  // Compare the fully assembled word once it is stable in DONE; the flag is
  // held until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (state == DONE) begin
      err <= (rx_word != mux_in);
    end
  end
`endif

  assign busy    = (state == SCAN);
  assign done    = (state == DONE);
  assign mux_sel = busy ? cnt : '0;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq with an inline 4:1 muxer that can be
// stuck at 0. A reference model plus an expected-bit queue checks every cycle;
// a vector table and a few hand sequences cover the corner cases.
module tb_mux_scan_seq;
  import mux_scan_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] mux_in;
  logic [1:0]   mux_sel;
  logic         mux_q;
  logic         ser_out;
  logic         ser_valid;
  logic [W-1:0] rx_word;
  logic         busy;
  logic         done;
`ifdef SCAN_CHECK_EN
  logic         err;
`endif
  logic         stuck;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mux_scan_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .mux_in   (mux_in),
    .mux_sel  (mux_sel),
    .mux_q    (mux_q),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .rx_word  (rx_word),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_CHECK_EN
    ,.err     (err)
`endif
  );

  // External 4:1 muxer with a stuck-at-0 output fault.
  assign mux_q = stuck ? 1'b0 : mux_in[mux_sel];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: 0 = idle, 1 = scan, 2 = done.
  int           m_st;
  int           m_cnt;
  logic [W-1:0] m_muxin;
  logic [W-1:0] m_rx;
  logic         m_valid;
  logic         m_err;
  bit           exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_st    <= 0;
      m_cnt   <= 0;
      m_muxin <= '0;
      m_rx    <= '0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      exp_q.delete();
    end else begin
      case (m_st)
        0: begin
          m_valid <= 1'b0;
          if (start) begin
            m_muxin <= data_in;
            m_rx    <= '0;
            m_cnt   <= 0;
            m_err   <= 1'b0;
            for (int k = 0; k < W; k++) exp_q.push_back(stuck ? 1'b0 : data_in[k]);
            m_st    <= 1;
          end
        end
        1: begin
          m_valid     <= 1'b1;
          m_rx[m_cnt] <= stuck ? 1'b0 : m_muxin[m_cnt];
          m_cnt       <= (m_cnt + 1) % W;
          if (m_cnt == W - 1) m_st <= 2;
        end
        default: begin
          m_valid <= 1'b0;
          m_err   <= (m_rx != m_muxin);
          m_st    <= 0;
        end
      endcase
    end
  end

  // Per-cycle monitor against the model and the expected-bit queue.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, m_st == 1);
      chk("done", done, m_st == 2);
      chk("ser_valid", ser_valid, m_valid);
      chk("mux_in", mux_in, m_muxin);
      chk("mux_sel", mux_sel, (m_st == 1) ? m_cnt : 0);
      chk("rx_word", rx_word, m_rx);
`ifdef SCAN_CHECK_EN
      chk("err", err, m_err);
`endif
      if (ser_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ser_extra: got ser_valid=1 expected no pending bit (cycle %0d)", cyc);
        end else begin
          chk("ser_out", ser_out, exp_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic         stuck;
    logic [W-1:0] exp_rx;
    logic         exp_err;
  } vec_t;

  vec_t vecs[9];

  // One scan: pulse start, scramble data_in after accept, wait for done.
  task automatic run_scan(input vec_t v);
    int  n;
    bit  got;
    stuck   = v.stuck;
    data_in = v.data;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = ~v.data;
    n   = 0;
    got = 1'b0;
    while (n < 12 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("done_latency", n, W + 1);
    chk("rx_at_done", rx_word, v.exp_rx);
    @(negedge clk);
`ifdef SCAN_CHECK_EN
    chk("err_after_done", err, v.exp_err);
`endif
    stuck = 1'b0;
  endtask

  initial begin
    int  first, second, rises, n;
    bit  prev, seen;

    vecs[0] = '{4'h1, 1'b0, 4'h1, 1'b0};
    vecs[1] = '{4'he, 1'b0, 4'he, 1'b0};
    vecs[2] = '{4'h5, 1'b0, 4'h5, 1'b0};
    vecs[3] = '{4'h8, 1'b1, 4'h0, 1'b1};
    vecs[4] = '{4'h8, 1'b0, 4'h8, 1'b0};
    vecs[5] = '{4'h0, 1'b0, 4'h0, 1'b0};
    vecs[6] = '{4'hf, 1'b1, 4'h0, 1'b1};
    vecs[7] = '{4'hf, 1'b0, 4'hf, 1'b0};
    vecs[8] = '{4'ha, 1'b0, 4'ha, 1'b0};

    rst = 1'b1; start = 1'b0; data_in = '0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset values and idle with start low.
    @(negedge clk);
    chk("rst_mux_in", mux_in, 0);
    chk("rst_mux_sel", mux_sel, 0);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_rx_word", rx_word, 0);
    chk("rst_done", done, 0);
`ifdef SCAN_CHECK_EN
    chk("rst_err", err, 0);
`endif
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("idle_busy_never", seen, 0);

    for (int i = 0; i < 9; i++) run_scan(vecs[i]);

    // Start held high: re-accept exactly W+2 cycles later.
    data_in = 4'he;
    start   = 1'b1;
    first = -1; second = -1; rises = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy && !prev) begin
        rises++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (done) chk("held_rx_at_done", rx_word, 4'he);
      prev = busy;
    end
    start = 1'b0;
    chk("held_first_accept", first, 0);
    chk("held_period", second - first, W + 2);
    chk("held_accept_count", rises, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || done) && n < 20);
    chk("held_settle", n < 20, 1);
    chk("held_rx_final", rx_word, 4'he);

    // Reset on the third scan cycle discards the partial word.
    data_in = 4'hf;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ser_valid", ser_valid, 0);
    chk("midrst_rx_word", rx_word, 0);
    chk("midrst_mux_in", mux_in, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);

    // Clean scan after the reset.
    run_scan(vecs[1]);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
